// File: rtl/id_ex_stage_pkg.sv
// mips_defs: ALU op codes, id_ctrl bit positions and the zero-register specifier shared by the ID/EX slice
package mips_defs;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the freshest value of one source register from EX/MEM, MEM/WB or the register file
module forward_unit
  import mips_defs::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic [REGBITS-1:0] src,
  input  logic [WIDTH-1:0]   reg_data,
  input  logic               exmem_reg_write,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_data,
  output logic [WIDTH-1:0]   data
);
  logic exmem_hit, memwb_hit;
  assign exmem_hit = exmem_reg_write && exmem_rd != REGBITS'(REG_ZERO) && exmem_rd == src;
  assign memwb_hit = memwb_reg_write && memwb_rd != REGBITS'(REG_ZERO) && memwb_rd == src;
  assign data = exmem_hit ? exmem_result : memwb_hit ? memwb_data : reg_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and operand forwarding
module id_ex_stage
  import mips_defs::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [3:0]         id_alu_control,
  input  logic [3:0]         id_ctrl,
  input  logic               id_alu_src,
  input  logic [WIDTH-1:0]   id_rs_data,
  input  logic [WIDTH-1:0]   id_rt_data,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic               exmem_reg_write,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_result,
  input  logic               memwb_reg_write,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_data,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [3:0]         ex_alu_control,
  output logic [3:0]         ex_ctrl,
  output logic [REGBITS-1:0] ex_rd,
  output logic [WIDTH-1:0]   ex_input_a,
  output logic [WIDTH-1:0]   ex_input_b,
  output logic [WIDTH-1:0]   ex_store_data
);
  typedef struct packed {
    logic               valid;
    logic [3:0]         alu_control;
    logic [3:0]         ctrl;
    logic               alu_src;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
  } ex_t;
  ex_t ex_q, ex_d;
  logic bubble;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  assign hazard_stall = !flush && id_valid && ex_q.valid && ex_q.ctrl[CTRL_MEM_READ] &&
                        ex_q.rd != REGBITS'(REG_ZERO) && (ex_q.rd == id_rs || ex_q.rd == id_rt);
  assign bubble = flush || hazard_stall || !id_valid;
  // A bubble clears the whole slot, so stale specifiers can never match a forwarding source.
  always_comb begin
    ex_d = bubble ? '0 : '{valid: 1'b1, alu_control: id_alu_control, ctrl: id_ctrl,
                           alu_src: id_alu_src, rs_data: id_rs_data, rt_data: id_rt_data,
                           imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ex_q <= '0;
    else ex_q <= ex_d;
  end
  forward_unit #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_a (
    .src(ex_q.rs), .reg_data(ex_q.rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .data(fwd_a)
  );
  forward_unit #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_fwd_b (
    .src(ex_q.rt), .reg_data(ex_q.rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .data(fwd_b)
  );
  assign ex_valid       = ex_q.valid;
  assign ex_alu_control = ex_q.alu_control;
  assign ex_ctrl        = ex_q.ctrl;
  assign ex_rd          = ex_q.rd;
  assign ex_input_a     = ex_q.valid ? fwd_a : '0;
  assign ex_input_b     = ex_q.valid ? (ex_q.alu_src ? ex_q.imm : fwd_b) : '0;
  assign ex_store_data  = ex_q.valid ? fwd_b : '0;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a behavioural pipeline model
module tb_id_ex_stage;
  localparam int W = 32;
  localparam int R = 5;
  logic clock, reset, flush, id_valid, id_alu_src;
  logic [3:0] id_alu_control, id_ctrl;
  logic [W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [R-1:0] id_rs, id_rt, id_rd;
  logic exmem_reg_write, memwb_reg_write;
  logic [R-1:0] exmem_rd, memwb_rd;
  logic [W-1:0] exmem_result, memwb_data;
  logic hazard_stall, ex_valid;
  logic [3:0] ex_alu_control, ex_ctrl;
  logic [R-1:0] ex_rd;
  logic [W-1:0] ex_input_a, ex_input_b, ex_store_data;
  int checks = 0;
  int errors = 0;

  id_ex_stage #(.WIDTH(W), .REGBITS(R)) dut (
    .clock(clock), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_alu_control(id_alu_control), .id_ctrl(id_ctrl), .id_alu_src(id_alu_src),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_alu_control(ex_alu_control),
    .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_input_a(ex_input_a), .ex_input_b(ex_input_b),
    .ex_store_data(ex_store_data)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Model of the instruction currently sitting in EX (all zero = bubble)
  typedef struct packed {
    logic v; logic [3:0] alu; logic [3:0] ctrl; logic src;
    logic [W-1:0] a, b, imm; logic [R-1:0] rs, rt, rd;
  } mex_t;
  mex_t m;

  function automatic logic [W-1:0] fwd(input logic [R-1:0] r, input logic [W-1:0] d);
    if (r == 0) return d;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_data;
    return d;
  endfunction

  function automatic logic exp_stall();
    if (flush || !id_valid || !m.v || !m.ctrl[2] || m.rd == 0) return 1'b0;
    return (m.rd == id_rs) || (m.rd == id_rt);
  endfunction

  function automatic logic [110:0] exp_vec();
    logic [W-1:0] fa, fb, ib;
    fa = fwd(m.rs, m.a);
    fb = fwd(m.rt, m.b);
    ib = m.src ? m.imm : fb;
    if (!m.v) begin fa = 0; fb = 0; ib = 0; end
    return {m.v, m.alu, m.ctrl, m.rd, fa, ib, fb, exp_stall()};
  endfunction

  function automatic logic [110:0] obs();
    return {ex_valid, ex_alu_control, ex_ctrl, ex_rd, ex_input_a, ex_input_b, ex_store_data, hazard_stall};
  endfunction

  task automatic tick();
    logic ld;
    ld = !(flush || exp_stall() || !id_valid);
    @(posedge clock);
    if (ld) m = '{v: 1'b1, alu: id_alu_control, ctrl: id_ctrl, src: id_alu_src, a: id_rs_data,
                  b: id_rt_data, imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd};
    else m = '0;
    #1;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
  endtask

  task automatic instr(input logic [3:0] alu, input logic [3:0] ctrl, input logic src,
                       input logic [R-1:0] rs, input logic [R-1:0] rt, input logic [R-1:0] rd,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm);
    id_valid = 1; id_alu_control = alu; id_ctrl = ctrl; id_alu_src = src;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b; id_imm = imm;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; no_fwd();
    instr(4'b0010, 4'b1000, 0, 1, 2, 3, 5, 7, 0);
    m = '0;
    #1;
    checks++;
    if (obs() !== 111'd0) begin errors++; $display("FAIL reset_state got=%h exp=0", obs()); end
    #3 reset = 0;
  endtask

  task automatic test_add();
    no_fwd(); flush = 0;
    instr(4'b0010, 4'b1000, 0, 1, 2, 3, 5, 7, 32'h99);
    tick();
    checks++;
    if ({ex_valid, ex_alu_control, ex_input_a, ex_input_b} !== {1'b1, 4'b0010, 32'd5, 32'd7}) begin
      errors++; $display("FAIL add_basic got v=%b alu=%b a=%h b=%h exp v=1 alu=0010 a=5 b=7",
                         ex_valid, ex_alu_control, ex_input_a, ex_input_b);
    end
    checks++;
    if (obs() !== exp_vec()) begin errors++; $display("FAIL add_model got=%h exp=%h", obs(), exp_vec()); end
    id_alu_src = 1;
    tick();
    checks++;
    if (ex_input_b !== 32'h99 || ex_store_data !== 32'd7) begin
      errors++; $display("FAIL alu_src_imm got b=%h sd=%h exp b=99 sd=7", ex_input_b, ex_store_data);
    end
  endtask

  task automatic test_fwd_priority();
    instr(4'b0110, 4'b1000, 0, 1, 1, 6, 32'h1, 32'h2, 0);
    exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'h10;
    memwb_reg_write = 1; memwb_rd = 1; memwb_data = 32'h20;
    tick();
    checks++;
    if (ex_input_a !== 32'h10 || ex_store_data !== 32'h10) begin
      errors++; $display("FAIL fwd_exmem_priority got a=%h sd=%h exp 10", ex_input_a, ex_store_data);
    end
    exmem_reg_write = 0;
    #1;
    checks++;
    if (ex_input_a !== 32'h20 || ex_input_b !== 32'h20) begin
      errors++; $display("FAIL fwd_memwb got a=%h b=%h exp 20", ex_input_a, ex_input_b);
    end
    memwb_reg_write = 0;
    #1;
    checks++;
    if (ex_input_a !== 32'h1) begin errors++; $display("FAIL fwd_none got a=%h exp 1", ex_input_a); end
  endtask

  task automatic test_load_use();
    no_fwd();
    instr(4'b0010, 4'b1100, 1, 2, 4, 4, 32'h100, 0, 32'h8);
    tick();
    instr(4'b0010, 4'b1000, 0, 4, 5, 7, 32'h0, 32'h3, 0);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got=%b exp=1", hazard_stall); end
    tick();
    checks++;
    if (ex_valid !== 0 || ex_ctrl !== 0 || ex_rd !== 0 || hazard_stall !== 0) begin
      errors++; $display("FAIL load_use_bubble got v=%b ctrl=%b rd=%0d st=%b exp all 0",
                         ex_valid, ex_ctrl, ex_rd, hazard_stall);
    end
    tick();
    memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'hABCD;
    #1;
    checks++;
    if (ex_valid !== 1 || ex_rd !== 5'd7 || ex_input_a !== 32'hABCD) begin
      errors++; $display("FAIL load_use_resume got v=%b rd=%0d a=%h exp v=1 rd=7 a=abcd",
                         ex_valid, ex_rd, ex_input_a);
    end
  endtask

  task automatic test_flush();
    no_fwd();
    instr(4'b0010, 4'b1100, 1, 2, 9, 9, 32'h100, 0, 0);
    tick();
    instr(4'b0010, 4'b1000, 0, 9, 1, 3, 32'h55, 0, 0);
    flush = 1;
    #1;
    checks++;
    if (hazard_stall !== 0) begin errors++; $display("FAIL flush_stall got=%b exp=0", hazard_stall); end
    tick();
    flush = 0;
    checks++;
    if (ex_valid !== 0 || ex_input_a !== 0 || ex_alu_control !== 0) begin
      errors++; $display("FAIL flush_bubble got v=%b a=%h alu=%b exp 0", ex_valid, ex_input_a, ex_alu_control);
    end
  endtask

  task automatic test_zero_reg();
    no_fwd();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_data = 32'hEEEE;
    instr(4'b0111, 4'b1000, 0, 0, 0, 2, 0, 0, 0);
    tick();
    checks++;
    if (ex_valid !== 1 || ex_input_a !== 0 || ex_store_data !== 0) begin
      errors++; $display("FAIL zero_reg got v=%b a=%h sd=%h exp v=1 a=0 sd=0", ex_valid, ex_input_a, ex_store_data);
    end
  endtask

  task automatic test_reset_mid_stall();
    no_fwd();
    instr(4'b0010, 4'b1100, 1, 2, 8, 8, 32'h40, 0, 0);
    tick();
    instr(4'b0110, 4'b1000, 0, 3, 8, 10, 32'h30, 32'h11, 0);
    #1;
    checks++;
    if (hazard_stall !== 1) begin errors++; $display("FAIL mid_stall_pre got=%b exp=1", hazard_stall); end
    reset = 1;
    m = '0;
    #1;
    checks++;
    if (obs() !== 111'd0) begin errors++; $display("FAIL reset_async got=%h exp=0", obs()); end
    reset = 0;
    tick();
    checks++;
    if (ex_valid !== 1 || ex_rd !== 5'd10 || ex_alu_control !== 4'b0110 || ex_input_b !== 32'h11) begin
      errors++; $display("FAIL reset_release got v=%b rd=%0d alu=%b b=%h exp v=1 rd=10 alu=0110 b=11",
                         ex_valid, ex_rd, ex_alu_control, ex_input_b);
    end
  endtask

  task automatic test_random();
    logic hold = 0;
    for (int i = 0; i < 200; i++) begin
      if (!hold) begin
        instr(4'($urandom), 4'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
        id_valid = ($urandom_range(0, 7) != 0);
      end
      flush = ($urandom_range(0, 9) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_data = $urandom;
      #1;
      checks++;
      if (obs() !== exp_vec()) begin errors++; $display("FAIL rand_pre[%0d] got=%h exp=%h", i, obs(), exp_vec()); end
      hold = exp_stall();
      tick();
      checks++;
      if (obs() !== exp_vec()) begin errors++; $display("FAIL rand_post[%0d] got=%h exp=%h", i, obs(), exp_vec()); end
    end
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_fwd_priority();
    test_load_use();
    test_flush();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
